// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory model.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

  localparam int WAIT_W = 4;

  // Byte 7 has no enable bit of its own; it follows byte 6.
  function automatic logic [7:0] expand_mask(input logic [6:0] mask);
    return {mask[6], mask};
  endfunction

endpackage

// File: rtl/mem_responder_sram.sv
// Single-port doubleword array with byte enables and synchronous read-before-write.
module mem_responder_sram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            be,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata
);

  logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

  // rdata always captures the old contents, so a store returns the pre-store word.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        for (int b = 0; b < 8; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Two-port (fetch/data) memory responder over a single-port array.
// Optional range checking is enabled by defining MEM_RESPONDER_RANGE_CHECK_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [63:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [63:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [6:0]  data_write_mask_in,
  input  logic [63:0] data_write_value_in,
  output logic [63:0] data_read_value_out,
  output logic        data_ready_out,
  output logic        err_out
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  state_t                state, state_d;
  grant_t                grant_q, last_grant;
  logic [WAIT_W-1:0]     cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  write_q, oor_q;
  logic [6:0]            mask_q;
  logic [63:0]           wdata_q, instr_hold, data_hold, sram_rdata, resp_value;
  logic                  instr_req, data_req, pick_data, access, sel_oor;
  logic [63:0]           sel_addr;
  logic                  unused_addr;

  assign instr_req = instr_read_in;
  assign data_req  = data_read_in | data_write_in;
  // Data wins a tie unless it won the previous grant.
  assign pick_data = data_req & (~instr_req | (last_grant != DATA));
  assign sel_addr  = pick_data ? data_address_in : instr_address_in;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  logic err_q;
  assign sel_oor     = |sel_addr[63:DEPTH_LOG2+3];
  assign unused_addr = ^sel_addr[2:0];
  assign err_out     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_q <= 1'b0;
    else if (access && oor_q)  err_q <= 1'b1;
  end
`else
  assign sel_oor     = 1'b0;
  assign unused_addr = ^{sel_addr[63:DEPTH_LOG2+3], sel_addr[2:0]};
  assign err_out     = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (instr_req || data_req) state_d = BUSY;
      BUSY:    if (cnt == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign access = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_q    <= INSTR;
      last_grant <= INSTR;
      cnt        <= '0;
      idx_q      <= '0;
      oor_q      <= 1'b0;
      write_q    <= 1'b0;
      mask_q     <= '0;
      wdata_q    <= '0;
      instr_hold <= '0;
      data_hold  <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (instr_req || data_req) begin
            if (pick_data) begin
              grant_q    <= DATA;
              last_grant <= DATA;
            end else begin
              grant_q    <= INSTR;
              last_grant <= INSTR;
            end
            idx_q   <= sel_addr[DEPTH_LOG2+2:3];
            oor_q   <= sel_oor;
            write_q <= pick_data & data_write_in;
            mask_q  <= data_write_mask_in;
            wdata_q <= data_write_value_in;
            cnt     <= WAIT_INIT;
          end
        end
        BUSY: if (cnt != '0) cnt <= cnt - WAIT_W'(1);
        RESP: begin
          if (grant_q == INSTR) instr_hold <= resp_value;
          else                  data_hold  <= resp_value;
        end
        default: ;
      endcase
    end
  end

  mem_responder_sram #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
    .clk   (clk),
    .en    (access),
    .we    (access & write_q & ~oor_q),
    .addr  (idx_q),
    .be    (expand_mask(mask_q)),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  assign resp_value = oor_q ? 64'd0 : sram_rdata;

  assign instr_ready_out      = (state == RESP) && (grant_q == INSTR);
  assign data_ready_out       = (state == RESP) && (grant_q == DATA);
  assign instr_read_value_out = instr_ready_out ? resp_value : instr_hold;
  assign data_read_value_out  = data_ready_out  ? resp_value : data_hold;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with WAIT_CYCLES=0, one with WAIT_CYCLES=3.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] i_addr [2];
  logic [63:0] d_addr [2];
  logic [63:0] d_wval [2];
  logic [63:0] i_rval [2];
  logic [63:0] d_rval [2];
  logic        i_rd   [2];
  logic        d_rd   [2];
  logic        d_wr   [2];
  logic        i_rdy  [2];
  logic        d_rdy  [2];
  logic        err    [2];
  logic [6:0]  d_mask [2];

  mem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .instr_address_in(i_addr[0]), .instr_read_in(i_rd[0]),
    .instr_read_value_out(i_rval[0]), .instr_ready_out(i_rdy[0]),
    .data_address_in(d_addr[0]), .data_read_in(d_rd[0]), .data_write_in(d_wr[0]),
    .data_write_mask_in(d_mask[0]), .data_write_value_in(d_wval[0]),
    .data_read_value_out(d_rval[0]), .data_ready_out(d_rdy[0]), .err_out(err[0])
  );

  mem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .instr_address_in(i_addr[1]), .instr_read_in(i_rd[1]),
    .instr_read_value_out(i_rval[1]), .instr_ready_out(i_rdy[1]),
    .data_address_in(d_addr[1]), .data_read_in(d_rd[1]), .data_write_in(d_wr[1]),
    .data_write_mask_in(d_mask[1]), .data_write_value_in(d_wval[1]),
    .data_read_value_out(d_rval[1]), .data_ready_out(d_rdy[1]), .err_out(err[1])
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];
  logic [63:0] model [int];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wdata,
                                        input logic [6:0] mask);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) begin
      if ((b < 7) ? mask[b] : mask[6]) r[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic bit out_of_range(input logic [63:0] addr);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    return addr[63:15] != '0;
`else
    return addr[63:15] != addr[63:15];
`endif
  endfunction

  task automatic idle_inputs(input int k);
    i_addr[k] = '0; i_rd[k] = 1'b0;
    d_addr[k] = '0; d_rd[k] = 1'b0; d_wr[k] = 1'b0;
    d_mask[k] = '0; d_wval[k] = '0;
  endtask

  // Starts and ends at a negedge; one full transaction on instance k.
  task automatic txn(input int k, input bit is_data, input bit wr, input bit rd,
                     input logic [63:0] addr, input logic [6:0] mask,
                     input logic [63:0] wdata, input string tag);
    int          key, cyc;
    bit          seen, oor;
    logic [63:0] pre;
    key = k * 4096 + int'(addr[14:3]);
    pre = model.exists(key) ? model[key] : 64'd0;
    oor = out_of_range(addr);
    exp_q.push_back(oor ? 64'd0 : pre);
    if (is_data && wr && !oor) model[key] = merge(pre, wdata, mask);
    if (is_data) begin
      d_addr[k] = addr; d_rd[k] = rd; d_wr[k] = wr; d_mask[k] = mask; d_wval[k] = wdata;
    end else begin
      i_addr[k] = addr; i_rd[k] = 1'b1;
    end
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (is_data ? d_rdy[k] : i_rdy[k]) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    i_rd[k] = 1'b0; d_rd[k] = 1'b0; d_wr[k] = 1'b0;
    if (!seen) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_front());
      @(negedge clk);
      return;
    end
    check({tag, "_latency"}, 64'(cyc + 1), (k == 0) ? 64'd2 : 64'd5);
    check({tag, "_other_ready"}, {63'd0, is_data ? i_rdy[k] : d_rdy[k]}, 64'd0);
    check({tag, "_value"}, is_data ? d_rval[k] : i_rval[k], exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ready_drop"}, {63'd0, is_data ? d_rdy[k] : i_rdy[k]}, 64'd0);
  endtask

  // Both ports held on instance 0: expect data, instr, data.
  task automatic arb_test();
    bit          port_q [$];
    bit          want_data;
    int          cyc;
    bit          seen;
    port_q = '{1'b1, 1'b0, 1'b1};
    exp_q.push_back(model[int'(64'h40 >> 3)]);
    exp_q.push_back(model[0]);
    exp_q.push_back(model[int'(64'h40 >> 3)]);
    i_addr[0] = 64'h0;  i_rd[0] = 1'b1;
    d_addr[0] = 64'h40; d_rd[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
        @(negedge clk);
        if (i_rdy[0] || d_rdy[0]) seen = 1'b1;
        else cyc++;
      end
      want_data = port_q.pop_front();
      if (n == 2) begin
        i_rd[0] = 1'b0; d_rd[0] = 1'b0;
      end
      if (!seen) begin
        check("arb_timeout", 64'd0, 64'd1);
        void'(exp_q.pop_front());
      end else begin
        check("arb_port", {62'd0, d_rdy[0], i_rdy[0]}, want_data ? 64'd2 : 64'd1);
        check("arb_value", want_data ? d_rval[0] : i_rval[0], exp_q.pop_front());
        @(negedge clk);
        check("arb_single", {62'd0, d_rdy[0], i_rdy[0]}, 64'd0);
      end
    end
    i_rd[0] = 1'b0; d_rd[0] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] fetched;
    logic [63:0] rnd;
    idle_inputs(0);
    idle_inputs(1);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", {62'd0, i_rdy[k], d_rdy[k]}, 64'd0);
      check("rst_ivalue", i_rval[k], 64'd0);
      check("rst_dvalue", d_rval[k], 64'd0);
      check("rst_err", {63'd0, err[k]}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait store/load, byte merge, read-before-write.
    txn(0, 1, 1, 0, 64'h0,  7'h7F, 64'hCAFE_0000_0000_BEEF, "st0");
    txn(0, 1, 1, 0, 64'h40, 7'h7F, 64'h1122_3344_5566_7788, "st40");
    txn(0, 1, 0, 1, 64'h40, 7'h00, 64'h0, "ld40");
    check("ld40_const", d_rval[0], 64'h1122_3344_5566_7788);
    txn(0, 1, 1, 0, 64'h45, 7'h01, 64'h0000_0000_0000_00AB, "stbyte");
    txn(0, 1, 0, 1, 64'h47, 7'h00, 64'h0, "ldbyte");
    check("ldbyte_const", d_rval[0], 64'h1122_3344_5566_77AB);
    txn(0, 1, 1, 1, 64'h48, 7'h40, 64'hFF00_0000_0000_0000, "rw_both");
    txn(0, 1, 0, 1, 64'h48, 7'h00, 64'h0, "ld48");
    for (int n = 0; n < 4; n++) begin
      rnd = {$urandom(), $urandom()};
      txn(0, 1, 1, 0, 64'(n * 8 + 'h100), 7'($urandom_range(0, 127)), rnd, "st_rand");
      txn(0, 1, 0, 1, 64'(n * 8 + 'h100), 7'h00, 64'h0, "ld_rand");
    end
    txn(0, 0, 0, 0, 64'h0, 7'h00, 64'h0, "fetch0");
    fetched = model[0];
    txn(0, 1, 0, 1, 64'h40, 7'h00, 64'h0, "ld_hold");
    check("ivalue_hold", i_rval[0], fetched);
    txn(0, 0, 0, 0, 64'h0, 7'h00, 64'h0, "fetch_last");
    arb_test();

    // Three-wait instance: latency and reset during BUSY.
    txn(1, 1, 1, 0, 64'h0,  7'h7F, 64'h0123_4567_89AB_CDEF, "w3_st0");
    txn(1, 0, 0, 0, 64'h0,  7'h00, 64'h0, "w3_fetch");
    txn(1, 1, 1, 0, 64'h80, 7'h7F, 64'hA5A5_A5A5_5A5A_5A5A, "w3_st80");
    d_addr[1] = 64'h80; d_wr[1] = 1'b1; d_mask[1] = 7'h7F; d_wval[1] = 64'hDEAD_DEAD_DEAD_DEAD;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {62'd0, i_rdy[1], d_rdy[1]}, 64'd0);
    check("mid_rst_dvalue", d_rval[1], 64'd0);
    check("mid_rst_ivalue", i_rval[1], 64'd0);
    idle_inputs(1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_quiet", {62'd0, i_rdy[1], d_rdy[1]}, 64'd0);
    end
    txn(1, 1, 0, 1, 64'h80, 7'h00, 64'h0, "w3_ld80");

    // High address bits: error path or wrap.
    txn(0, 1, 0, 1, 64'h10000, 7'h00, 64'h0, "ld_high");
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    check("err_set", {63'd0, err[0]}, 64'd1);
    txn(0, 1, 0, 1, 64'h40, 7'h00, 64'h0, "ld_after_err");
    check("err_sticky", {63'd0, err[0]}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("err_cleared", {63'd0, err[0]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    check("err_tied", {63'd0, err[0]}, 64'd0);
`endif
    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, log2 of array depth in 64-bit doublewords.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra access cycles per request (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr_address_in  input  64  instruction fetch byte address.
REQ-006 SHALL have port instr_read_in  input  1  instruction fetch request, held until ready.
REQ-007 SHALL have port instr_read_value_out  output  64  fetched doubleword.
REQ-008 SHALL have port instr_ready_out  output  1  one-cycle completion pulse for fetch.
REQ-009 SHALL have port data_address_in  input  64  data byte address.
REQ-010 SHALL have port data_read_in  input  1  load request, held until ready.
REQ-011 SHALL have port data_write_in  input  1  store request, held until ready.
REQ-012 SHALL have port data_write_mask_in  input  7  store byte enables.
REQ-013 SHALL have port data_write_value_in  input  64  store data.
REQ-014 SHALL have port data_read_value_out  output  64  loaded doubleword.
REQ-015 SHALL have port data_ready_out  output  1  one-cycle completion pulse for load/store.
REQ-016 SHALL have port err_out  output  1  sticky out-of-range flag.

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; single-port array, one access per transaction.
REQ-018 IDLE: SHALL grant when any request present, latch port/address/mask/write data, load wait counter with WAIT_CYCLES, go BUSY.
REQ-019 Arbitration: both ports requesting -> data granted unless last grant was data, then instr granted; last_grant resets to instr.
REQ-020 BUSY: counter nonzero -> decrement; counter zero -> perform array access, go RESP.
REQ-021 RESP: SHALL assert exactly the granted port's ready for one cycle with its read value valid, then go IDLE.
REQ-022 Latency: request sampled in IDLE at cycle t -> ready at t+2+WAIT_CYCLES; next grant no earlier than t+3+WAIT_CYCLES.
REQ-023 Request inputs outside IDLE SHALL be ignored; no request is served twice.
REQ-024 Array index = address[DEPTH_LOG2+2:3]; address[2:0] ignored; full doubleword returned.
REQ-025 Store: byte i (0..6) written iff mask[i]; byte 7 written iff mask[6]; unmasked bytes unchanged.
REQ-026 data_write_in and data_read_in both high -> store performed, one data_ready pulse.
REQ-027 Store: data_read_value_out SHALL return the pre-store doubleword.
REQ-028 Read-value outputs SHALL hold last value between transactions.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counter 0, last_grant instr, both ready outputs 0, both read values 0, err_out 0.
REQ-030 Reset mid-transaction SHALL abort it without array write (unless already committed) and without ready pulse; array contents are not reset.

Configuration
REQ-031 MEM_RESPONDER_RANGE_CHECK_EN defined: address[63:DEPTH_LOG2+3] nonzero -> no array write, read value 0, ready still pulses, err_out set until reset.
REQ-032 MEM_RESPONDER_RANGE_CHECK_EN undefined: high address bits ignored (wrap modulo depth), err_out tied 0.

Structure
REQ-033 Package mem_responder_pkg SHALL hold state enum (IDLE/BUSY/RESP), grant enum (INSTR/DATA), WAIT counter width constant.
REQ-034 Sub-module mem_responder_sram SHALL hold the array: single port, 8 byte enables, synchronous read-before-write.

Verification
REQ-035 WAIT_CYCLES=0: store 0x1122334455667788 mask 0x7F at 0x40, then load 0x40 -> data_ready 2 cycles after each sampling, read 0x1122334455667788.
REQ-036 Byte store 0xAB mask 0x01 at 0x40 over above -> load returns 0x11223344556677AB.
REQ-037 Simultaneous fetch 0x0 and load 0x40 held 3 transactions -> grants data, instr, data; each ready single-cycle.
REQ-038 WAIT_CYCLES=3: fetch at cycle 10 -> instr_ready exactly cycle 15, low cycles 11-14 and 16.
REQ-039 rst_n low during BUSY of store to 0x80 -> no ready pulse, outputs zeroed, 0x80 contents unchanged on later load.
REQ-040 With RANGE_CHECK_EN, DEPTH_LOG2=12: load 0x10000 -> read 0, data_ready pulses, err_out 1 until reset; without macro same load returns contents of 0x0.
